// File: rtl/lcd_mode_sequencer.sv
// LCD dot/line sequencer: PPU mode FSM, LY counter, LY/LYC compare, VBlank/STAT requests, memory-busy flags.
// Optional: define STAT_IRQ_BLOCKING_EN to make STAT requests edge-triggered on the OR of all enabled sources.
module lcd_mode_sequencer #(
  parameter int unsigned DOTS_PER_LINE = 456,
  parameter int unsigned OAM_DOTS      = 80,
  parameter int unsigned XFER_DOTS     = 172,
  parameter int unsigned VISIBLE_LINES = 144,
  parameter int unsigned TOTAL_LINES   = 154
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic       coincidence,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       oam_busy,
  output logic       vram_busy
);

  localparam int unsigned DOT_W = 9;
  localparam int unsigned LY_W  = 8;
  localparam int unsigned SRC_W = 4;

  typedef enum logic [2:0] {S_OFF, S_OAM, S_XFER, S_HBLANK, S_VBLANK} state_e;

  state_e             state_q, state_d;
  logic [DOT_W-1:0]   dot_q, dot_d;
  logic [LY_W-1:0]    ly_q, ly_d;
  logic [1:0]         mode_q, mode_d;
  logic               coincidence_q, coincidence_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               vblank_irq_q, vblank_irq_d;
  logic               stat_irq_q, stat_irq_d;
  logic               oam_busy_q, oam_busy_d;
  logic               vram_busy_q, vram_busy_d;
  logic [SRC_W-1:0]   src_hist_q, src_hist_d;
  logic [SRC_W-1:0]   src_c;
  logic               stat_rise_c;

  // Mode region for a given position in the frame.
  function automatic state_e line_state(input logic [DOT_W-1:0] d, input logic [LY_W-1:0] l);
    if (l >= LY_W'(VISIBLE_LINES))               return S_VBLANK;
    else if (d < DOT_W'(OAM_DOTS))               return S_OAM;
    else if (d < DOT_W'(OAM_DOTS + XFER_DOTS))   return S_XFER;
    else                                         return S_HBLANK;
  endfunction

  function automatic logic [1:0] mode_of(input state_e s);
    case (s)
      S_OAM:    return 2'd2;
      S_XFER:   return 2'd3;
      S_VBLANK: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

  // STAT sources are taken from the registered mode/coincidence, so requests trail them by one clk.
  always_comb begin
    src_c = '0;
    if (state_q != S_OFF) begin
      src_c = {stat_ie[3] & coincidence_q,
               stat_ie[2] & (mode_q == 2'd2),
               stat_ie[1] & (mode_q == 2'd1),
               stat_ie[0] & (mode_q == 2'd0)};
    end
`ifdef STAT_IRQ_BLOCKING_EN
    stat_rise_c = (|src_c) & ~(|src_hist_q);
`else
    stat_rise_c = |(src_c & ~src_hist_q);
`endif
  end

  always_comb begin
    state_d       = state_q;
    dot_d         = dot_q;
    ly_d          = ly_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    vblank_irq_d  = 1'b0;

    if (!lcd_enable) begin
      state_d = S_OFF;
      dot_d   = '0;
      ly_d    = '0;
    end else if (state_q == S_OFF) begin
      state_d       = S_OAM;
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (dot_en) begin
      if (dot_q == DOT_W'(DOTS_PER_LINE - 1)) begin
        dot_d        = '0;
        line_start_d = 1'b1;
        if (ly_q == LY_W'(TOTAL_LINES - 1)) begin
          ly_d          = '0;
          frame_start_d = 1'b1;
        end else begin
          ly_d         = ly_q + LY_W'(1);
          vblank_irq_d = (ly_d == LY_W'(VISIBLE_LINES));
        end
      end else begin
        dot_d = dot_q + DOT_W'(1);
      end
      state_d = line_state(dot_d, ly_d);
    end

    mode_d        = mode_of(state_d);
    oam_busy_d    = (state_d == S_OAM) || (state_d == S_XFER);
    vram_busy_d   = (state_d == S_XFER);
    coincidence_d = (state_d != S_OFF) && (ly_d == lyc);
    src_hist_d    = lcd_enable ? src_c : '0;
    stat_irq_d    = lcd_enable & stat_rise_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_OFF;
      dot_q         <= '0;
      ly_q          <= '0;
      mode_q        <= '0;
      coincidence_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_irq_q  <= 1'b0;
      stat_irq_q    <= 1'b0;
      oam_busy_q    <= 1'b0;
      vram_busy_q   <= 1'b0;
      src_hist_q    <= '0;
    end else begin
      state_q       <= state_d;
      dot_q         <= dot_d;
      ly_q          <= ly_d;
      mode_q        <= mode_d;
      coincidence_q <= coincidence_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_irq_q  <= vblank_irq_d;
      stat_irq_q    <= stat_irq_d;
      oam_busy_q    <= oam_busy_d;
      vram_busy_q   <= vram_busy_d;
      src_hist_q    <= src_hist_d;
    end
  end

  assign mode        = mode_q;
  assign ly          = ly_q;
  assign dot         = dot_q;
  assign coincidence = coincidence_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vblank_irq  = vblank_irq_q;
  assign stat_irq    = stat_irq_q;
  assign oam_busy    = oam_busy_q;
  assign vram_busy   = vram_busy_q;

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Directed bench for lcd_mode_sequencer: reset, line/frame timing, LYC compare, STAT edges, LCD off/on.
module tb_lcd_mode_sequencer;

  logic       clk;
  logic       reset;
  logic       dot_en;
  logic       lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic [1:0] mode;
  logic [7:0] ly;
  logic [8:0] dot;
  logic       coincidence, line_start, frame_start, vblank_irq, stat_irq, oam_busy, vram_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  lcd_mode_sequencer dut (
    .clk(clk), .reset(reset), .dot_en(dot_en), .lcd_enable(lcd_enable),
    .lyc(lyc), .stat_ie(stat_ie), .mode(mode), .ly(ly), .dot(dot),
    .coincidence(coincidence), .line_start(line_start), .frame_start(frame_start),
    .vblank_irq(vblank_irq), .stat_irq(stat_irq), .oam_busy(oam_busy), .vram_busy(vram_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clk; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t0, guard, n2, n3, n0, nv, ncoin, npulse, nls, nvb;
    int p1_ly, p1_dot, p2_ly, p2_dot;

    reset = 1'b1; dot_en = 1'b1; lcd_enable = 1'b1; lyc = 8'd0; stat_ie = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_ly", 32'(ly), 32'd0);
      check("rst_dot", 32'(dot), 32'd0);
      check("rst_coin", 32'(coincidence), 32'd0);
      check("rst_pulses", 32'({line_start, frame_start, vblank_irq, stat_irq}), 32'd0);
      check("rst_busy", 32'({oam_busy, vram_busy}), 32'd0);
    end

    // First clk after release: OFF -> OAM, no dot advance.
    reset = 1'b0;
    tick();
    t0 = cyc;
    check("en_mode", 32'(mode), 32'd2);
    check("en_line_start", 32'(line_start), 32'd1);
    check("en_frame_start", 32'(frame_start), 32'd1);
    check("en_dot", 32'(dot), 32'd0);
    check("en_oam_busy", 32'(oam_busy), 32'd1);
    check("en_coin_ly0", 32'(coincidence), 32'd1);
    lyc = 8'd200;

    // Line 0 mode profile.
    n2 = 0; n3 = 0; n0 = 0; nv = 0;
    for (int i = 0; i < 456; i++) begin
      if (i > 0) tick();
      if (mode == 2'd2) n2++;
      if (mode == 2'd3) n3++;
      if (mode == 2'd0) n0++;
      if (vram_busy) nv++;
    end
    check("l0_mode2_clks", 32'(n2), 32'd80);
    check("l0_mode3_clks", 32'(n3), 32'd172);
    check("l0_vram_busy_clks", 32'(nv), 32'd172);
    check("l0_mode0_clks", 32'(n0), 32'd204);
    check("l0_last_dot", 32'(dot), 32'd455);
    tick();
    check("l1_ly", 32'(ly), 32'd1);
    check("l1_dot", 32'(dot), 32'd0);
    check("l1_line_start", 32'(line_start), 32'd1);
    check("l1_frame_start", 32'(frame_start), 32'd0);
    check("l1_mode", 32'(mode), 32'd2);

    // LYC=5 coincidence window with a single STAT request at entry.
    lyc = 8'd5; stat_ie = 4'b1000;
    guard = 0; ncoin = 0; npulse = 0; p1_ly = 0; p1_dot = 0;
    while (!(ly == 8'd6 && dot == 9'd0) && guard < 3000) begin
      tick(); guard++;
      if (coincidence) ncoin++;
      if (stat_irq) begin
        npulse++;
        p1_ly = 32'(ly); p1_dot = 32'(dot);
      end
    end
    check("lyc5_reached_ly6", 32'(ly == 8'd6 && dot == 9'd0), 32'd1);
    check("lyc5_coin_clks", 32'(ncoin), 32'd456);
    check("lyc5_stat_pulses", 32'(npulse), 32'd1);
    check("lyc5_stat_ly", 32'(p1_ly), 32'd5);
    check("lyc5_stat_dot", 32'(p1_dot), 32'd1);

    // lyc written to the current line: coincidence after 1 clk, STAT after 2.
    lyc = 8'd6;
    tick();
    check("lycw_coin", 32'(coincidence), 32'd1);
    check("lycw_stat_early", 32'(stat_irq), 32'd0);
    tick();
    check("lycw_stat", 32'(stat_irq), 32'd1);
    tick();
    check("lycw_stat_one_clk", 32'(stat_irq), 32'd0);

    // HBlank of ly9 into ly10 with mode0 and coincidence enabled.
    stat_ie = 4'b1001; lyc = 8'd10;
    guard = 0; npulse = 0; p1_ly = 0; p1_dot = 0; p2_ly = 0; p2_dot = 0;
    while (!(ly == 8'd10 && dot == 9'd10) && guard < 3000) begin
      tick(); guard++;
      if (stat_irq && (ly == 8'd9 || ly == 8'd10)) begin
        npulse++;
        if (npulse == 1) begin p1_ly = 32'(ly); p1_dot = 32'(dot); end
        else begin p2_ly = 32'(ly); p2_dot = 32'(dot); end
      end
    end
    check("blk_reached", 32'(ly == 8'd10 && dot == 9'd10), 32'd1);
    check("blk_first_ly", 32'(p1_ly), 32'd9);
    check("blk_first_dot", 32'(p1_dot), 32'd253);
`ifdef STAT_IRQ_BLOCKING_EN
    check("blk_pulses", 32'(npulse), 32'd1);
`else
    check("blk_pulses", 32'(npulse), 32'd2);
    check("blk_second_ly", 32'(p2_ly), 32'd10);
    check("blk_second_dot", 32'(p2_dot), 32'd1);
`endif

    // Remainder of frame: VBlank entry and frame wrap.
    stat_ie = 4'd0; lyc = 8'd200;
    nls = 0; nvb = 0;
    while (!frame_start && (cyc - t0) < 70300) begin
      tick();
      if (line_start) nls++;
      if (vblank_irq) begin
        nvb++;
        check("vb_ly", 32'(ly), 32'd144);
        check("vb_dot", 32'(dot), 32'd0);
        check("vb_mode", 32'(mode), 32'd1);
        check("vb_oam_busy", 32'(oam_busy), 32'd0);
      end
    end
    check("frame_clks", 32'(cyc - t0), 32'd70224);
    check("frame_ly", 32'(ly), 32'd0);
    check("frame_line_start", 32'(line_start), 32'd1);
    check("frame_mode", 32'(mode), 32'd2);
    check("vb_pulses", 32'(nvb), 32'd1);
    check("frame_line_starts", 32'(nls), 32'd144);

    // LCD off mid-line at ly=50, dot=200.
    lyc = 8'd50;
    guard = 0;
    while (!(ly == 8'd50 && dot == 9'd200) && guard < 25000) begin
      tick(); guard++;
    end
    check("off_reached", 32'(ly == 8'd50 && dot == 9'd200), 32'd1);
    check("off_pre_coin", 32'(coincidence), 32'd1);
    lcd_enable = 1'b0;
    tick();
    check("off_mode", 32'(mode), 32'd0);
    check("off_ly", 32'(ly), 32'd0);
    check("off_dot", 32'(dot), 32'd0);
    check("off_coin", 32'(coincidence), 32'd0);
    check("off_busy", 32'({oam_busy, vram_busy}), 32'd0);
    tick();
    check("off_hold_dot", 32'(dot), 32'd0);
    check("off_no_pulses", 32'({line_start, frame_start, vblank_irq, stat_irq}), 32'd0);

    // Re-enable, then hold with dot_en low.
    lcd_enable = 1'b1;
    tick();
    check("reen_mode", 32'(mode), 32'd2);
    check("reen_ly", 32'(ly), 32'd0);
    check("reen_frame_start", 32'(frame_start), 32'd1);
    dot_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("hold_dot", 32'(dot), 32'd0);
    check("hold_frame_start", 32'(frame_start), 32'd0);
    dot_en = 1'b1;
    tick();
    check("resume_dot", 32'(dot), 32'd1);
    for (int i = 0; i < 454; i++) tick();
    check("pre_wrap_dot", 32'(dot), 32'd455);

    // Dropping enable on the wrap cycle suppresses the line_start pulse.
    lcd_enable = 1'b0;
    tick();
    check("supp_line_start", 32'(line_start), 32'd0);
    check("supp_ly", 32'(ly), 32'd0);
    check("supp_mode", 32'(mode), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
